// File: rtl/ad9866_spi_sched.sv
`default_nettype none
// ============================================================================
// Module      : ad9866_spi_sched
// Description : Request scheduler in front of the AD9866 SPI configuration
//               engine. Merges RX gain, TX gain and generic host register
//               writes into the engine's single 16-bit write port, one
//               transaction at a time, and holds all traffic until the
//               engine's init sequence has finished.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   init_done          engine init table sent; nothing is issued while low
//   rx_gain_wr/rx_gain RX PGA gain strobe + 6-bit code (register 0x09)
//   tx_gain_wr/tx_gain TX gain strobe + 6-bit code (register 0x0a)
//   host_valid/ready   generic write handshake, host_addr[4:0]/host_data[7:0]
//   spi_start          one-cycle start pulse to the SPI engine
//   spi_word           {3'b000, addr, data}, held through the transaction
//   spi_sen_n          engine chip enable (high = idle)
//   busy               transaction in flight or any slot pending
//   tx_gain_ok         last latched TX gain has reached the chip
//   err_timeout        sticky: engine never dropped spi_sen_n after a start
//   wr_count           completed transactions (wraps)
// ============================================================================
module ad9866_spi_sched #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        rx_gain_wr,
  input  logic [5:0]  rx_gain,
  input  logic        tx_gain_wr,
  input  logic [5:0]  tx_gain,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [4:0]  host_addr,
  input  logic [7:0]  host_data,
  output logic        spi_start,
  output logic [15:0] spi_word,
  input  logic        spi_sen_n,
  output logic        busy,
  output logic        tx_gain_ok,
  output logic        err_timeout,
  output logic [7:0]  wr_count
);

  localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
  localparam logic [3:0]         c_GAP      = 4'(GAP_CYCLES);
  localparam logic [4:0]         c_ADDR_RX  = 5'h09;
  localparam logic [4:0]         c_ADDR_TX  = 5'h0a;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

  state_t             r_state;
  logic [3:0]         r_gap;
  logic [c_TMO_W-1:0] r_tmo;
  logic               r_spi_start;
  logic [15:0]        r_spi_word;
  logic               r_cur_tx;    // transaction in flight came from the TX slot
  logic               r_tx_dirty;  // tx_gain_wr seen since the TX slot was last selected
  logic               r_tx_ok;
  logic               r_err;
  logic [7:0]         r_wr_count;

  logic               r_rx_pend;
  logic [5:0]         r_rx_val;
  logic               r_tx_pend;
  logic [5:0]         r_tx_val;
  logic               r_host_pend;
  logic [4:0]         r_host_addr;
  logic [7:0]         r_host_data;

  logic w_any_pend;
  logic w_can_sel;
  logic w_sel_tx;
  logic w_sel_rx;
  logic w_sel_host;
  logic w_host_acc;

  assign w_any_pend = r_rx_pend | r_tx_pend | r_host_pend;
  assign w_can_sel  = (r_state == S_IDLE) && (r_gap == 4'd0) && init_done &&
                      spi_sen_n && w_any_pend;
  // Fixed priority TX > RX > HOST; HOST wins only when it is the one pending.
  assign w_sel_tx   = w_can_sel && r_tx_pend;
  assign w_sel_rx   = w_can_sel && !r_tx_pend && r_rx_pend;
  assign w_sel_host = w_can_sel && !r_tx_pend && !r_rx_pend;
  assign w_host_acc = host_valid && !r_host_pend;

  // Request slots. A strobe in the selection cycle wins over the clear, so
  // the old value goes out now and the new one stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_pend   <= 1'b0;
      r_rx_val    <= 6'd0;
      r_tx_pend   <= 1'b0;
      r_tx_val    <= 6'd0;
      r_host_pend <= 1'b0;
      r_host_addr <= 5'd0;
      r_host_data <= 8'd0;
    end else begin
      if (rx_gain_wr) begin
        r_rx_pend <= 1'b1;
        r_rx_val  <= rx_gain;
      end else if (w_sel_rx) begin
        r_rx_pend <= 1'b0;
      end

      if (tx_gain_wr) begin
        r_tx_pend <= 1'b1;
        r_tx_val  <= tx_gain;
      end else if (w_sel_tx) begin
        r_tx_pend <= 1'b0;
      end

      if (w_host_acc) begin
        r_host_pend <= 1'b1;
        r_host_addr <= host_addr;
        r_host_data <= host_data;
      end else if (w_sel_host) begin
        r_host_pend <= 1'b0;
      end
    end
  end

  // Transaction sequencer and its registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gap       <= 4'd0;
      r_tmo       <= '0;
      r_spi_start <= 1'b0;
      r_spi_word  <= 16'd0;
      r_cur_tx    <= 1'b0;
      r_tx_dirty  <= 1'b0;
      r_tx_ok     <= 1'b0;
      r_err       <= 1'b0;
      r_wr_count  <= 8'd0;
    end else begin
      r_spi_start <= 1'b0;
      if (tx_gain_wr) begin
        r_tx_dirty <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_gap != 4'd0) begin
            r_gap <= r_gap - 4'd1;
          end else if (w_can_sel) begin
            r_state     <= S_ISSUE;
            r_spi_start <= 1'b1;
            r_cur_tx    <= w_sel_tx;
            // A TX strobe in this very cycle already makes this write stale.
            r_tx_dirty  <= tx_gain_wr;
            if (w_sel_tx) begin
              r_spi_word <= {3'b000, c_ADDR_TX, 2'b01, r_tx_val};
            end else if (w_sel_rx) begin
              r_spi_word <= {3'b000, c_ADDR_RX, 2'b01, r_rx_val};
            end else begin
              r_spi_word <= {3'b000, r_host_addr, r_host_data};
            end
          end
        end

        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_LOW;
        end

        S_WAIT_LOW: begin
          if (!spi_sen_n) begin
            r_state <= S_WAIT_HIGH;
          end else if (r_tmo == c_TMO_LAST) begin
            // Engine never responded: drop the write, keep the gap anyway.
            r_err   <= 1'b1;
            r_gap   <= c_GAP;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + c_TMO_ONE;
          end
        end

        S_WAIT_HIGH: begin
          if (spi_sen_n) begin
            r_wr_count <= r_wr_count + 8'd1;
            if (r_cur_tx && !r_tx_dirty) begin
              r_tx_ok <= 1'b1;
            end
            r_gap   <= c_GAP;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // A new TX gain invalidates the flag, even in a completion cycle.
      if (tx_gain_wr) begin
        r_tx_ok <= 1'b0;
      end
    end
  end

  assign host_ready  = !r_host_pend;
  assign busy        = (r_state != S_IDLE) | w_any_pend;
  assign spi_start   = r_spi_start;
  assign spi_word    = r_spi_word;
  assign tx_gain_ok  = r_tx_ok;
  assign err_timeout = r_err;
  assign wr_count    = r_wr_count;

endmodule
`default_nettype wire
